data_sram_arbiter: RTL
======================

// Module: data_sram_arbiter
// PURPOSE
//  Shares the single-port synchronous data SRAM between two masters: m0 = EXE-stage load/store port, m1 = auxiliary
//  port (uncached fetch/debug/DMA). One access per cycle, same-cycle grant, read data one cycle later.
//  Round-robin on conflict; optional bounded burst lock. Sits between exe_stage/aux master and the data SRAM macro.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width (byte-enable width = DATA_W/8)
//  MAX_BURST   4  max consecutive granted beats under lock (>=1)
// PORTS
//  clk          in   1          clock; all state on posedge
//  reset        in   1          synchronous, active-high
//  mN_req       in   1          N=0,1: access request; addr/wen/wdata valid while high
//  mN_lock      in   1          request lock: keep grant for following beats
//  mN_wen       in   DATA_W/8   byte write enables; 0 = read
//  mN_addr      in   ADDR_W     byte address
//  mN_wdata     in   DATA_W     store data
//  mN_gnt       out  1          access accepted this cycle (combinational)
//  mN_rvalid    out  1          response for access granted previous cycle
//  mN_rdata     out  DATA_W     = sram_rdata; meaningful only with mN_rvalid on a read
//  sram_en      out  1          SRAM enable
//  sram_wen     out  DATA_W/8   SRAM byte write enable
//  sram_addr    out  ADDR_W     SRAM address
//  sram_wdata   out  DATA_W     SRAM write data
//  sram_rdata   in   DATA_W     SRAM read data, valid cycle after sram_en
// BEHAVIOUR
//  - Reset: state=ARB, prio_r=0 (m0 favoured), beat_cnt=0, rvalid_r=0. While reset high: mN_gnt=0, sram_en=0,
//    sram_wen=0, sram_addr=0, sram_wdata=0, mN_rvalid=0.
//  - Master rule: req/addr/wen/wdata held stable until gnt; arbiter does not check.
//  - At most one gnt per cycle. sram_en = m0_gnt|m1_gnt; sram_* muxed from winner; all sram_* = 0 when no grant.
//  - Latency: rvalid to winner exactly 1 cycle after gnt (owner_r, rvalid_r regs); also for writes (write ack).
//    Throughput 1/cycle: new gnt and previous rvalid coexist in one cycle.
//  - FSM ARB / LOCK0 / LOCK1.
//   ARB: single requester wins. Both: winner = prio_r. On any grant prio_r <= ~winner.
//        Winner with lock=1 -> LOCKw, beat_cnt <= 1; else stay ARB.
//   LOCKn, holder req=1: only mn granted; other gnt=0. beat_cnt++ per grant.
//        lock=0 on this beat -> grant, then ARB. beat_cnt reaches MAX_BURST -> grant, then ARB with prio_r = other
//        (forced release; holder re-competes normally).
//   LOCKn, holder req=0: lock released same cycle; cycle arbitrated as ARB (other may win); next state per ARB rules.
//  - MAX_BURST=1: lock has no effect (always ARB). Worst-case wait of a requesting master: MAX_BURST cycles.
//  - beat_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST.
//  - reset mid-burst/mid-response: in-flight rvalid dropped, no rvalid in cycle after reset deasserts.
// STRUCTURE
//  - mycpu.h: ARB_ST_* state encodings (2 bits), ARB_M0/ARB_M1 ids, default MAX_BURST.
//  - Sub-module arb2_rr_pick (combinational): req[1:0], prio, lock_mask[1:0] -> one-hot gnt[1:0].
//  - Top: FSM, prio_r, beat_cnt, owner_r/rvalid_r, SRAM mux.
// TESTING
//  - Reset: reset=1 with both req=1 -> gnt=00, sram_en=0; first cycle after: m0 granted (prio 0).
//  - Alternation: both req read 0x100/0x200 for 4 cycles -> gnt m0,m1,m0,m1; rvalid to same master next cycle,
//    rdata = SRAM contents.
//  - Single master: m1 only, 3 back-to-back stores wen=4'hf, then read -> gnt every cycle, rvalid each next cycle,
//    read returns last stored word.
//  - Lock bound: MAX_BURST=4, m0 req+lock continuous, m1 req -> m0 granted 4 beats, m1 granted 5th cycle.
//  - Early release: m0 lock 2 beats, lock=0 on 3rd -> 3 m0 grants then m1; m0 drops req in LOCK0 -> m1 granted
//    same cycle.
//  - Reset mid-burst: reset in LOCK0 beat 2 -> no rvalid after, state ARB, prio 0, both req -> m0 first.

Source files
------------

// File: rtl/data_sram_arbiter_pkg.sv
// Shared types and constants for the data SRAM arbiter.
// No logic; no latency.
// No backpressure.
package data_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_ST_ARB   = 2'd0,
    ARB_ST_LOCK0 = 2'd1,
    ARB_ST_LOCK1 = 2'd2
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/data_sram_arbiter_pick.sv
// Two-way round-robin pick with optional lock mask restricting the eligible set.
// Combinational, zero latency.
// No backpressure; losers simply see gnt=0.
module arb2_rr_pick
  import data_sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic [1:0] lock_mask,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  always_comb begin
    elig = (lock_mask != 2'b00) ? (req & lock_mask) : req;
    gnt  = elig;
    if (elig == 2'b11) begin
      gnt = (prio == ARB_M1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/data_sram_arbiter.sv
// Shares one single-port data SRAM between the EXE load/store port (m0) and an aux port (m1).
// Grant is same-cycle combinational; rvalid/rdata return exactly one cycle after the grant.
// Backpressure: a losing master holds req/addr/wen/wdata until it sees gnt.
module data_sram_arbiter
  import data_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_lock,
  input  logic [DATA_W/8-1:0] m0_wen,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_lock,
  input  logic [DATA_W/8-1:0] m1_wen,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e  state;
  logic        prio_r;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_next;
  logic        owner_r;
  logic        rvalid_r;

  logic [1:0]  lock_mask;
  logic [1:0]  gnt_raw;
  logic [1:0]  gnt;
  logic        holder_act;
  logic        winner;
  logic        any_gnt;
  logic        win_lock;

  // The lock only constrains the pick while the holder keeps requesting;
  // once it drops req the cycle is arbitrated normally.
  always_comb begin
    lock_mask = 2'b00;
    if (state == ARB_ST_LOCK0 && m0_req) begin
      lock_mask = 2'b01;
    end else if (state == ARB_ST_LOCK1 && m1_req) begin
      lock_mask = 2'b10;
    end
  end

  assign holder_act = |lock_mask;

  arb2_rr_pick u_pick (
    .req       ({m1_req, m0_req}),
    .prio      (prio_r),
    .lock_mask (lock_mask),
    .gnt       (gnt_raw)
  );

  assign gnt       = reset ? 2'b00 : gnt_raw;
  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign any_gnt   = |gnt;
  assign winner    = gnt[1] ? ARB_M1 : ARB_M0;
  assign win_lock  = (winner == ARB_M1) ? m1_lock : m0_lock;
  assign beat_next = beat_cnt + BW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_ST_ARB;
      prio_r   <= ARB_M0;
      beat_cnt <= '0;
      owner_r  <= ARB_M0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= any_gnt;
      owner_r  <= winner;
      if (any_gnt) begin
        prio_r <= ~winner;
      end
      if (holder_act) begin
        // Holder beat: leave on voluntary release or when the burst bound is hit.
        if (!win_lock || beat_next >= BW'(MAX_BURST)) begin
          state    <= ARB_ST_ARB;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_next;
        end
      end else if (any_gnt && win_lock && MAX_BURST > 1) begin
        state    <= (winner == ARB_M1) ? ARB_ST_LOCK1 : ARB_ST_LOCK0;
        beat_cnt <= BW'(1);
      end else begin
        state    <= ARB_ST_ARB;
        beat_cnt <= '0;
      end
    end
  end

  always_comb begin
    sram_en    = any_gnt;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt[0]) begin
      sram_wen   = m0_wen;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end else if (gnt[1]) begin
      sram_wen   = m1_wen;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end
  end

  assign m0_rvalid = rvalid_r && (owner_r == ARB_M0) && !reset;
  assign m1_rvalid = rvalid_r && (owner_r == ARB_M1) && !reset;
  assign m0_rdata  = sram_rdata;
  assign m1_rdata  = sram_rdata;

endmodule
